// File: rtl/bus_pkg.sv
// Shared definitions for the bus controller: FSM encoding and default parameters.
package bus_pkg;

  // Controller states
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2,
    StErr    = 2'd3
  } bus_state_e;

  // Default configuration
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned SEL_W_DEF    = 2;
  localparam int unsigned N_SLV_DEF    = 3;
  localparam int unsigned WAIT_CYC_DEF = 1;
  localparam logic [2:0]  RO_MASK_DEF  = 3'b001;

  // Wait counter width, enough for WAIT_CYC up to 15
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/bus_wait_cnt.sv
// Access wait counter: loads a start value, counts down to zero and holds there.
module bus_wait_cnt
  import bus_pkg::*;
#(
  parameter int unsigned CntW = CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [CntW-1:0] i_load_val,
  input  logic            i_dec,
  output logic            o_zero
);

  logic [CntW-1:0] r_cnt;

  // Load has priority over decrement; decrement saturates at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bus_ctrl.sv
// Single-master bus controller: decodes a slave index from the upper address
// bits, runs a fixed-length access with wait states, and reports completion or
// rejection (unpopulated slave / write to read-only slave) with a ready pulse.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned      DATA_W   = DATA_W_DEF,
  parameter int unsigned      ADDR_W   = ADDR_W_DEF,
  parameter int unsigned      SEL_W    = SEL_W_DEF,
  parameter int unsigned      N_SLV    = N_SLV_DEF,
  parameter int unsigned      WAIT_CYC = WAIT_CYC_DEF,
  parameter logic [N_SLV-1:0] RO_MASK  = N_SLV'(RO_MASK_DEF)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    ready,
  output logic                    err,
  output logic [N_SLV-1:0]        s_en,
  output logic                    s_read,
  output logic                    s_write,
  output logic [ADDR_W-1:0]       s_addr,
  output logic [DATA_W-1:0]       s_wdata,
  input  logic [N_SLV*DATA_W-1:0] s_rdata
);

  bus_state_e r_state;
  bus_state_e w_state_next;

  logic [SEL_W-1:0]  w_idx_in;
  logic              w_idx_ok;
  logic              w_ro;
  logic              w_reject;
  logic              w_accept;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_zero;
  logic              w_capture;
  logic [DATA_W-1:0] w_slv_rdata;

  logic              r_we;
  logic [SEL_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  // Request decode on the live core inputs; only used on the accepting edge
  assign w_idx_in = addr[ADDR_W-1 -: SEL_W];
  // Extra bit so N_SLV == 2**SEL_W does not wrap to zero
  assign w_idx_ok = ({1'b0, w_idx_in} < (SEL_W + 1)'(N_SLV));
  assign w_reject = !w_idx_ok || (we && w_ro);
  assign w_accept = (r_state == StIdle) && req;

  // Read-only attribute of the addressed slave (0 for unpopulated indices)
  always_comb begin
    w_ro = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (w_idx_in == SEL_W'(i)) begin
        w_ro = RO_MASK[i];
      end
    end
  end

  // Read data of the latched slave
  always_comb begin
    w_slv_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (r_idx == SEL_W'(i)) begin
        w_slv_rdata = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_cnt_load = w_accept && !w_reject;
  assign w_cnt_dec  = (r_state == StAccess) && !w_cnt_zero;
  assign w_capture  = (r_state == StAccess) && w_cnt_zero && !r_we;

  bus_wait_cnt #(
    .CntW (CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(WAIT_CYC)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; DONE/ERR always return to IDLE so a held req
  // is taken on the following IDLE edge
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (req) begin
          w_state_next = w_reject ? StErr : StAccess;
        end
      end
      StAccess: begin
        if (w_cnt_zero) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      StErr:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs; strobes only in ACCESS, so s_en is one-hot or zero
  always_comb begin
    ready   = 1'b0;
    err     = 1'b0;
    s_read  = 1'b0;
    s_write = 1'b0;
    s_en    = '0;
    case (r_state)
      StAccess: begin
        s_read  = !r_we;
        s_write = r_we;
        for (int i = 0; i < N_SLV; i++) begin
          s_en[i] = (r_idx == SEL_W'(i));
        end
      end
      StDone: begin
        ready = 1'b1;
      end
      StErr: begin
        ready = 1'b1;
        err   = 1'b1;
      end
      default: ;
    endcase
  end

  // Transfer latches, taken only on the accepting edge so later input
  // changes cannot disturb the transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= we;
      r_idx   <= w_idx_in;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  // Read data register, updated only at the end of a successful read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_capture) begin
      r_rdata <= w_slv_rdata;
    end
  end

  assign rdata   = r_rdata;
  assign s_addr  = r_addr;
  assign s_wdata = r_wdata;

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl: directed scenarios plus random transfers
// checked against a transaction-level model of the bus rules.
module tb_bus_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned SW = 2;
  localparam int unsigned NS = 3;
  localparam int unsigned WC = 1;
  localparam logic [NS-1:0] RO = 3'b001;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic              we;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     rdata;
  logic              ready;
  logic              err;
  logic [NS-1:0]     s_en;
  logic              s_read;
  logic              s_write;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [NS*DW-1:0]  s_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  bus_ctrl #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .SEL_W    (SW),
    .N_SLV    (NS),
    .WAIT_CYC (WC),
    .RO_MASK  (RO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .s_en    (s_en),
    .s_read  (s_read),
    .s_write (s_write),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_s_en"}, 32'(s_en), 0);
    chk({tag, "_strobes"}, 32'({s_read, s_write}), 0);
    chk({tag, "_s_addr"}, 32'(s_addr), 0);
    chk({tag, "_s_wdata"}, 32'(s_wdata), 0);
  endtask

  // Follows one transfer from the cycle after its accepting edge to its
  // ready cycle; expectations come from the decode rules and latency
  task automatic watch(input logic w_we, input logic [7:0] a, input logic [7:0] wd,
                       input string tag);
    int idx;
    bit bad;
    int lat;
    idx = int'(a[7:6]);
    bad = (idx >= int'(NS)) ? 1'b1 : (w_we && RO[idx]);
    lat = bad ? 1 : int'(WC) + 2;
    for (int k = 1; k <= lat; k++) begin
      chk({tag, "_onehot0"}, 32'($onehot0(s_en)), 1);
      chk({tag, "_rd_and_wr"}, 32'(s_read & s_write), 0);
      if (k < lat) begin
        chk({tag, "_ready_early"}, 32'(ready), 0);
        chk({tag, "_s_en"}, 32'(s_en), 32'(1 << idx));
        chk({tag, "_s_read"}, 32'(s_read), 32'(!w_we));
        chk({tag, "_s_write"}, 32'(s_write), 32'(w_we));
        chk({tag, "_s_addr"}, 32'(s_addr), 32'(a));
        if (w_we) chk({tag, "_s_wdata"}, 32'(s_wdata), 32'(wd));
        chk({tag, "_rdata_hold"}, 32'(rdata), 32'(m_rdata));
        tick();
      end else begin
        if (!bad && !w_we) m_rdata = s_rdata[idx*8 +: 8];
        chk({tag, "_ready"}, 32'(ready), 1);
        chk({tag, "_err"}, 32'(err), 32'(bad));
        chk({tag, "_s_en_end"}, 32'(s_en), 0);
        chk({tag, "_strobes_end"}, 32'({s_read, s_write}), 0);
        chk({tag, "_rdata"}, 32'(rdata), 32'(m_rdata));
      end
    end
  endtask

  // Single transfer; core inputs are scrambled right after acceptance
  task automatic xfer(input logic w_we, input logic [7:0] a, input logic [7:0] wd,
                      input string tag);
    req   = 1'b1;
    we    = w_we;
    addr  = a;
    wdata = wd;
    tick();
    req   = 1'b0;
    we    = 1'($urandom);
    addr  = 8'($urandom);
    wdata = 8'($urandom);
    watch(w_we, a, wd, tag);
    tick();
    chk({tag, "_idle_ready"}, 32'(ready), 0);
    chk({tag, "_idle_s_en"}, 32'(s_en), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    s_rdata = '0;
    m_rdata = '0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Read slave 1
    s_rdata = {8'h3E, 8'hA5, 8'h11};
    xfer(1'b0, 8'h45, 8'h00, "rd_s1");
    // Write slave 2
    xfer(1'b1, 8'h80, 8'h3C, "wr_s2");
    // Write to read-only slave 0
    xfer(1'b1, 8'h10, 8'h99, "wr_ro");
    // Read unpopulated index 3
    xfer(1'b0, 8'hC0, 8'h00, "rd_nslv");

    // Back-to-back reads with req held and address changed mid-transfer
    s_rdata = {8'h77, 8'hC3, 8'h5A};
    req  = 1'b1;
    we   = 1'b0;
    addr = 8'h41;
    tick();
    addr = 8'h02;
    watch(1'b0, 8'h41, 8'h00, "b2b_first");
    tick();
    chk("b2b_gap_ready", 32'(ready), 0);
    chk("b2b_gap_s_en", 32'(s_en), 0);
    tick();
    req = 1'b0;
    watch(1'b0, 8'h02, 8'h00, "b2b_second");
    tick();
    chk("b2b_idle_ready", 32'(ready), 0);

    // Reset pulse in the middle of an access
    req  = 1'b1;
    we   = 1'b0;
    addr = 8'h85;
    tick();
    req = 1'b0;
    chk("abort_in_access", 32'(s_en), 32'(3'b100));
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("abort_async");
    repeat (3) begin
      tick();
      chk("abort_no_ready", 32'(ready), 0);
    end
    rst_n   = 1'b1;
    m_rdata = '0;
    tick();
    chk_all_zero("abort_released");
    xfer(1'b0, 8'h45, 8'h00, "after_abort");

    // Random transfers
    for (int n = 0; n < 40; n++) begin
      s_rdata = 24'($urandom);
      xfer(1'($urandom), 8'($urandom), 8'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bus width.
REQ-002 SHALL have parameter ADDR_W, default 8, address bus width.
REQ-003 SHALL have parameter SEL_W, default 2, upper address bits used as slave index.
REQ-004 SHALL have parameter N_SLV, default 3, number of populated slaves (1..2^SEL_W).
REQ-005 SHALL have parameter WAIT_CYC, default 1, extra access cycles per transfer (0..15).
REQ-006 SHALL have parameter RO_MASK, N_SLV bits, default 3'b001, bit i=1 marks slave i read-only (ROM).
REQ-007 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port req, input, 1, core transfer request.
REQ-010 SHALL have port we, input, 1, 1=write, 0=read.
REQ-011 SHALL have port addr, input, ADDR_W, core address.
REQ-012 SHALL have port wdata, input, DATA_W, core write data.
REQ-013 SHALL have port rdata, output, DATA_W, registered read data to core.
REQ-014 SHALL have port ready, output, 1, one-cycle transfer-complete pulse.
REQ-015 SHALL have port err, output, 1, qualified by ready; transfer rejected.
REQ-016 SHALL have port s_en, output, N_SLV, one-hot slave enable.
REQ-017 SHALL have ports s_read and s_write, output, 1 each, slave strobes.
REQ-018 SHALL have port s_addr, output, ADDR_W, latched address to slaves.
REQ-019 SHALL have port s_wdata, output, DATA_W, latched write data to slaves.
REQ-020 SHALL have port s_rdata, input, N_SLV*DATA_W, slave i read data at bits [i*DATA_W +: DATA_W].

Function
REQ-021 SHALL implement FSM IDLE, ACCESS, DONE, ERR.
REQ-022 IDLE: req=1 at clock edge SHALL latch addr, we, wdata; index = addr[ADDR_W-1 -: SEL_W].
REQ-023 IDLE: index>=N_SLV, or we=1 with RO_MASK[index]=1, SHALL go to ERR; otherwise ACCESS with wait counter loaded to WAIT_CYC.
REQ-024 ACCESS: s_en[index]=1, s_read=~we, s_write=we, s_addr/s_wdata stable from latched values; counter decrements each cycle.
REQ-025 ACCESS with counter==0 SHALL capture s_rdata slice into rdata (reads only; rdata unchanged on writes) and go to DONE.
REQ-026 DONE: ready=1, err=0 for exactly one cycle, all slave strobes 0, then IDLE.
REQ-027 ERR: ready=1, err=1 for exactly one cycle, no slave strobe ever asserted, then IDLE.
REQ-028 Latency: ready SHALL rise WAIT_CYC+2 cycles after the accepting edge; error latency 1 cycle.
REQ-029 req outside IDLE SHALL be ignored; req held high through DONE/ERR SHALL start a new transfer from the following IDLE cycle (throughput one transfer per WAIT_CYC+3 cycles).
REQ-030 Changes to addr/we/wdata after acceptance SHALL NOT affect the transfer in progress.
REQ-031 s_en SHALL be one-hot or zero at all times; s_read and s_write never both 1.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, counter=0, rdata=0, ready=0, err=0, s_en=0, s_read=0, s_write=0, s_addr=0, s_wdata=0.
REQ-033 Reset during ACCESS SHALL abort the transfer with no ready pulse; first request after release is accepted normally.

Structure
REQ-034 FSM state encoding and default parameter constants (widths, WAIT_CYC, RO_MASK) SHALL live in shared package bus_pkg.
REQ-035 Wait counter SHALL be a separate sub-module bus_wait_cnt (load, decrement, zero flag).
REQ-036 SHALL be usable as drop-in bus master for the existing core/RAM/ROM system with N_SLV=2.

Verification
REQ-037 Read slave 1 (addr 8'h45, s_rdata slice 1=8'hA5), WAIT_CYC=1 -> s_en=3'b010, s_read=1 for 2 cycles, ready at cycle 3, rdata=8'hA5, err=0.
REQ-038 Write slave 2 (addr 8'h80, wdata 8'h3C) -> s_write=1, s_addr=8'h80, s_wdata=8'h3C, ready=1, err=0.
REQ-039 Write slave 0 (addr 8'h10, RO) -> ready=1, err=1 next cycle, s_en stays 0.
REQ-040 Read addr 8'hC0 (index 3>=N_SLV) -> ready=1, err=1, no strobes, rdata unchanged.
REQ-041 req held high for two reads, addr changed mid-transfer -> first completes with original address, second accepted one cycle after first ready.
REQ-042 rst_n pulsed low during ACCESS -> all outputs 0 immediately, no ready; following read completes normally.
